// File: rtl/mux_select_arbiter_if.sv
// Bundle of the request vector and the registered mux-control outputs of the
// 8:1 mux select arbiter. The master modport is the arbiter side.
interface mux_select_arbiter_if;
    logic [7:0] req;
    logic [2:0] select;
    logic       enable;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    modport master (
        input  req,
        output select,
        output enable,
        output grant,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        input  select,
        input  enable,
        input  grant,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter that owns an 8:1 mux, with a hold limit per grant and a
// one-cycle break-before-make gap between owners. All outputs are registered.
module mux_select_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_select_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state;
    state_t     state_next;
    logic [2:0] last_owner;
    logic [2:0] last_owner_next;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_next;
    logic [2:0] select_q;
    logic [2:0] select_next;
    logic       enable_q;
    logic       enable_next;
    logic [7:0] grant_q;
    logic [7:0] grant_next;
    logic       busy_q;
    logic       busy_next;
    logic       timeout_q;
    logic       timeout_next;

    logic [2:0] rr_idx;
    logic [2:0] rr_winner;
    logic       rr_found;

    // Search starts just after the previous owner so it is considered last.
    always_comb begin
        rr_idx    = last_owner;
        rr_winner = last_owner;
        rr_found  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            rr_idx = last_owner + 3'(i);
            if (!rr_found && bus.req[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        hold_cnt_next   = hold_cnt;
        select_next     = select_q;
        enable_next     = enable_q;
        grant_next      = grant_q;
        timeout_next    = 1'b0;

        case (state)
            IDLE: begin
                enable_next = 1'b0;
                grant_next  = 8'h00;
                if (rr_found) begin
                    state_next      = OWN;
                    select_next     = rr_winner;
                    grant_next      = 8'b0000_0001 << rr_winner;
                    enable_next     = 1'b1;
                    last_owner_next = rr_winner;
                    hold_cnt_next   = 8'd1;
                end
            end
            OWN: begin
                // A dropped request wins over the hold limit: that is a normal release.
                if (!bus.req[last_owner]) begin
                    state_next  = GAP;
                    enable_next = 1'b0;
                    grant_next  = 8'h00;
                end else if (hold_cnt >= HOLD_LIMIT) begin
                    state_next   = GAP;
                    enable_next  = 1'b0;
                    grant_next   = 8'h00;
                    timeout_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end
            GAP: begin
                state_next    = IDLE;
                enable_next   = 1'b0;
                grant_next    = 8'h00;
                hold_cnt_next = 8'd0;
            end
            default: begin
                state_next  = IDLE;
                enable_next = 1'b0;
                grant_next  = 8'h00;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 3'd7;
            hold_cnt   <= 8'd0;
            select_q   <= 3'd0;
            enable_q   <= 1'b0;
            grant_q    <= 8'h00;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            hold_cnt   <= hold_cnt_next;
            select_q   <= select_next;
            enable_q   <= enable_next;
            grant_q    <= grant_next;
            busy_q     <= busy_next;
            timeout_q  <= timeout_next;
        end
    end

    assign bus.select  = select_q;
    assign bus.enable  = enable_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench: three arbiters (hold limits 8, 2, 1) share one request
// vector; a grant-level reference model feeds a queue that monitors drain.
module tb_mux_select_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int owner;
        int len;
        bit to;
    } exp_t;

    always #5 clk = ~clk;

    mux_select_arbiter_if bus0 ();
    mux_select_arbiter_if bus1 ();
    mux_select_arbiter_if bus2 ();

    assign bus0.req = req;
    assign bus1.req = req;
    assign bus2.req = req;

    mux_select_arbiter #(.MAX_HOLD(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mux_select_arbiter #(.MAX_HOLD(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux_select_arbiter #(.MAX_HOLD(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [2:0] sel_a [3];
    logic       en_a  [3];
    logic [7:0] gnt_a [3];
    logic       busy_a[3];
    logic       to_a  [3];

    assign sel_a[0] = bus0.select;  assign sel_a[1] = bus1.select;  assign sel_a[2] = bus2.select;
    assign en_a[0]  = bus0.enable;  assign en_a[1]  = bus1.enable;  assign en_a[2]  = bus2.enable;
    assign gnt_a[0] = bus0.grant;   assign gnt_a[1] = bus1.grant;   assign gnt_a[2] = bus2.grant;
    assign busy_a[0] = bus0.busy;   assign busy_a[1] = bus1.busy;   assign busy_a[2] = bus2.busy;
    assign to_a[0]  = bus0.timeout; assign to_a[1]  = bus1.timeout; assign to_a[2]  = bus2.timeout;

    task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input int cycles);
        req = r;
        repeat (cycles) @(negedge clk);
    endtask

    for (genvar k = 0; k < 3; k++) begin : gen_chk
        localparam int MAXH = (k == 0) ? 8 : ((k == 1) ? 2 : 1);

        exp_t exp_q[$];
        int   m_owner = -1;
        int   m_len = 0;
        int   m_cool = 0;
        int   m_last = 7;
        int   m_sel = 0;
        bit   e_en = 1'b0;
        bit   e_busy = 1'b0;
        bit   e_to = 1'b0;

        // Grant-level reference: an owner keeps the mux until its request drops
        // or it has used MAXH cycles, then one idle cycle must pass before the
        // next grant, chosen round-robin after the previous owner.
        initial begin : model
            exp_t e;
            bit   found;
            int   c;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_owner = -1; m_len = 0; m_cool = 0; m_last = 7; m_sel = 0;
                    e_en = 0; e_busy = 0; e_to = 0;
                    exp_q.delete();
                end else begin
                    e_to = 0;
                    if (m_owner >= 0) begin
                        if (!req[m_owner] || m_len == MAXH) begin
                            e.owner = m_owner;
                            e.len   = m_len;
                            e.to    = req[m_owner];
                            e_to    = e.to;
                            exp_q.push_back(e);
                            m_owner = -1;
                            m_cool  = 1;
                        end else begin
                            m_len++;
                        end
                    end else if (m_cool > 0) begin
                        m_cool--;
                    end else if (req != 8'h00) begin
                        found = 0;
                        for (int i = 1; i <= 8; i++) begin
                            c = (m_last + i) % 8;
                            if (!found && req[c]) begin
                                found   = 1;
                                m_owner = c;
                            end
                        end
                        m_len  = 1;
                        m_last = m_owner;
                        m_sel  = m_owner;
                    end
                    e_en   = (m_owner >= 0);
                    e_busy = (m_owner >= 0) || (m_cool > 0);
                end
            end
        end

        // Per-cycle output check plus one scoreboard pop per completed grant.
        initial begin : monitor
            int         cnt;
            bit         in_own;
            logic [7:0] cap_grant;
            exp_t       e;
            cnt = 0;
            in_own = 0;
            cap_grant = 8'h00;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    in_own = 0;
                    cnt = 0;
                end else begin
                    checkOutput("enable", k, 32'(en_a[k]), 32'(e_en));
                    checkOutput("busy", k, 32'(busy_a[k]), 32'(e_busy));
                    checkOutput("timeout", k, 32'(to_a[k]), 32'(e_to));
                    checkOutput("select", k, 32'(sel_a[k]), 32'(m_sel));
                    if (en_a[k] && !in_own) begin
                        in_own = 1;
                        cnt = 1;
                        cap_grant = gnt_a[k];
                    end else if (en_a[k]) begin
                        cnt++;
                    end else if (in_own) begin
                        in_own = 0;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("[TB] FAIL grant_release dut%0d: got release of grant %0h, expected none", k, cap_grant);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("grant_owner", k, 32'(cap_grant), 32'(8'h01 << e.owner));
                            checkOutput("grant_length", k, 32'(cnt), 32'(e.len));
                            checkOutput("release_timeout", k, 32'(to_a[k]), 32'(e.to));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] r;

        // Reset values.
        rst_n = 1'b0;
        req = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("rst_select", k, 32'(sel_a[k]), 32'd0);
            checkOutput("rst_enable", k, 32'(en_a[k]), 32'd0);
            checkOutput("rst_grant", k, 32'(gnt_a[k]), 32'd0);
            checkOutput("rst_busy", k, 32'(busy_a[k]), 32'd0);
            checkOutput("rst_timeout", k, 32'(to_a[k]), 32'd0);
        end
        rst_n = 1'b1;

        // First arbitration after reset favours requester 0, one-cycle latency.
        applyStimulus(8'h81, 1);
        checkOutput("first_grant", 0, 32'(gnt_a[0]), 32'h01);
        checkOutput("first_select", 0, 32'(sel_a[0]), 32'd0);
        applyStimulus(8'h81, 40);
        applyStimulus(8'h00, 4);

        // Everyone requesting permanently.
        applyStimulus(8'hFF, 70);
        applyStimulus(8'h00, 4);

        // Short request on input 3: normal release, select stays at 3.
        applyStimulus(8'h08, 3);
        applyStimulus(8'h00, 6);
        checkOutput("select_hold", 0, 32'(sel_a[0]), 32'd3);

        // Request dropped exactly when the hold limit is reached.
        applyStimulus(8'h20, 8);
        applyStimulus(8'h00, 6);
        applyStimulus(8'h20, 2);
        applyStimulus(8'h00, 6);

        // Two requesters held with tight hold limits.
        applyStimulus(8'h06, 20);
        applyStimulus(8'h00, 4);

        // Asynchronous reset mid-ownership.
        applyStimulus(8'h20, 3);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("async_rst_enable", k, 32'(en_a[k]), 32'd0);
            checkOutput("async_rst_grant", k, 32'(gnt_a[k]), 32'd0);
            checkOutput("async_rst_busy", k, 32'(busy_a[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h10, 1);
        for (int k = 0; k < 3; k++)
            checkOutput("post_rst_grant", k, 32'(gnt_a[k]), 32'h10);
        applyStimulus(8'h10, 3);
        applyStimulus(8'h00, 6);

        // Randomized request traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom);
                if ($urandom_range(0, 1) == 1)
                    r = r & 8'($urandom);
                req = r;
            end
            @(negedge clk);
        end

        applyStimulus(8'h00, 12);
        checkOutput("pending_grants", 0, 32'(gen_chk[0].exp_q.size()), 32'd0);
        checkOutput("pending_grants", 1, 32'(gen_chk[1].exp_q.size()), 32'd0);
        checkOutput("pending_grants", 2, 32'(gen_chk[2].exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive ownership cycles per grant; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 req  input  8  SHALL carry per-requester level requests; bit i maps to mux input i (a..h).
REQ-005 select  output  3  SHALL drive the 8:1 mux select with the current/last owner index.
REQ-006 enable  output  1  SHALL drive the mux enable; high only while an owner holds the mux.
REQ-007 grant  output  8  SHALL be a one-hot owner indication, all-zero when no owner.
REQ-008 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-009 timeout  output  1  SHALL pulse one cycle when an owner is cut off by MAX_HOLD.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, OWN, GAP; all outputs SHALL be registered.
REQ-011 IDLE with req==0: remain IDLE; enable=0, grant=0, select holds.
REQ-012 IDLE with req!=0: choose the winner by round-robin search starting at (last_owner+1) mod 8, ascending, wrapping 7->0.
REQ-013 On that same edge: state->OWN, select<=winner, grant<=1<<winner, enable<=1, last_owner<=winner, hold_cnt<=1.
REQ-014 Grant latency SHALL be exactly one cycle: req sampled high in IDLE at edge N gives enable=1 after edge N.
REQ-015 OWN with req[owner]==0 at an edge: state->GAP, enable<=0, grant<=0, timeout stays 0.
REQ-016 OWN with req[owner]==1 and hold_cnt==MAX_HOLD: state->GAP, enable<=0, grant<=0, timeout<=1 for one cycle.
REQ-017 OWN otherwise: hold_cnt<=hold_cnt+1; outputs unchanged; hold_cnt SHALL be 8 bits and never wrap (bounded by MAX_HOLD).
REQ-018 Simultaneous req[owner] drop and hold_cnt==MAX_HOLD SHALL be treated as a normal release (timeout=0).
REQ-019 GAP SHALL last exactly one cycle with enable=0 and grant=0 (break-before-make), then go to IDLE unconditionally.
REQ-020 select SHALL remain at the last owner through GAP and IDLE until the next grant.
REQ-021 Changes to req bits other than the owner's SHALL not affect OWN.
REQ-022 A timed-out requester keeping req high SHALL only regain the mux after all other pending requesters have been served once (round-robin fairness).
REQ-023 With MAX_HOLD=1, every grant SHALL last exactly one cycle; timeout pulses if req[owner] is still high.
REQ-024 Minimum ownership period SHALL be 1 cycle, and the minimum turnaround between grants 2 cycles (GAP+IDLE).

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force: state=IDLE, select=0, enable=0, grant=0, busy=0, timeout=0, hold_cnt=0, last_owner=7.
REQ-026 Reset during OWN SHALL drop enable and grant asynchronously; no timeout pulse is generated.
REQ-027 After rst_n deasserts, the first arbitration SHALL favour requester 0 (search from index 0).

Verification
REQ-028 Reset, then req=8'b1000_0001 held -> grant=0x01, select=0 one cycle later; after MAX_HOLD=8 cycles, timeout pulse, GAP, IDLE, then grant=0x80, select=7.
REQ-029 req=0xFF held permanently, MAX_HOLD=2 -> grants cycle 0,1,2,...,7,0 each lasting 2 cycles, with a timeout pulse on each, separated by 2-cycle gaps.
REQ-030 req[3] raised for 3 cycles then dropped -> enable high for 3 cycles, GAP, IDLE, timeout never asserted, select stays 3.
REQ-031 req[5] dropped on the same edge that hold_cnt reaches MAX_HOLD -> normal release, timeout=0.
REQ-032 rst_n pulsed low mid-OWN between clock edges -> enable/grant/busy go 0 before the next edge; with req=0x10 after release -> grant=0x10 one cycle later.
REQ-033 MAX_HOLD=1, req=0x06 held -> alternating grants to 1 and 2, each 1 cycle, with timeout pulses and 2-cycle gaps.
